// File: rtl/sva_check_sequencer_if.sv
// Load/run/result bundle between a bench and the a/b stimulus sequencer.
// The bench side is master (drives table loads, start, checker result); the sequencer is slave.
interface sva_check_sequencer_if #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
);
    localparam int AW = $clog2(DEPTH);

    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic              ld_a;
    logic              ld_b;
    logic [HOLD_W-1:0] ld_hold;
    logic [AW:0]       num_steps;
    logic              start;
    logic              chk_ok;
    logic              a;
    logic              b;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic              fail_seen;
    logic [AW-1:0]     first_fail_step;

    modport master (
        output ld_en, ld_addr, ld_a, ld_b, ld_hold, num_steps, start, chk_ok,
        input  a, b, busy, done, pass_cnt, fail_cnt, fail_seen, first_fail_step
    );

    modport slave (
        input  ld_en, ld_addr, ld_a, ld_b, ld_hold, num_steps, start, chk_ok,
        output a, b, busy, done, pass_cnt, fail_cnt, fail_seen, first_fail_step
    );
endinterface

// File: rtl/sva_check_sequencer.sv
// Replays a table of (a, b, hold) steps onto the checked signals and scores the checker's result.
// a/b registered, first step driven on the edge that accepts start; done one cycle after last RUN cycle.
module sva_check_sequencer #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sva_check_sequencer_if.slave  sif
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW:0]      DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic              a;
        logic              b;
        logic [HOLD_W-1:0] hold;
    } step_t;

    logic [1:0]        state;
    step_t             tbl [DEPTH];
    logic [AW-1:0]     step_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [AW:0]       steps_lat;
    logic              a_q;
    logic              b_q;
    logic [CNT_W-1:0]  pass_q;
    logic [CNT_W-1:0]  fail_q;
    logic              seen_q;
    logic [AW-1:0]     ffs_q;

    step_t         ld_ent;
    step_t         first_ent;
    step_t         next_ent;
    logic [AW:0]   steps_clamped;
    logic [AW-1:0] next_idx;
    logic          last_step;
    logic          ld_wr;

    assign ld_ent = {sif.ld_a, sif.ld_b, sif.ld_hold};
    assign ld_wr  = (state == S_IDLE) && sif.ld_en;

    // A write to entry 0 on the start cycle must reach the first step, so forward it.
    assign first_ent     = (ld_wr && (sif.ld_addr == '0)) ? ld_ent : tbl[0];
    assign steps_clamped = (sif.num_steps > DEPTH_V) ? DEPTH_V : sif.num_steps;
    assign next_idx      = step_idx + AW'(1);
    assign next_ent      = tbl[next_idx];
    assign last_step     = ({1'b0, step_idx} == (steps_lat - (AW+1)'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (ld_wr) begin
            tbl[sif.ld_addr] <= ld_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            step_idx  <= '0;
            hold_cnt  <= '0;
            steps_lat <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            pass_q    <= '0;
            fail_q    <= '0;
            seen_q    <= 1'b0;
            ffs_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    a_q <= 1'b0;
                    b_q <= 1'b0;
                    if (sif.start) begin
                        pass_q    <= '0;
                        fail_q    <= '0;
                        seen_q    <= 1'b0;
                        ffs_q     <= '0;
                        steps_lat <= steps_clamped;
                        step_idx  <= '0;
                        if (steps_clamped == '0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_RUN;
                            a_q      <= first_ent.a;
                            b_q      <= first_ent.b;
                            hold_cnt <= first_ent.hold;
                        end
                    end
                end

                S_RUN: begin
                    if (sif.chk_ok) begin
                        if (pass_q != CNT_MAX) pass_q <= pass_q + CNT_W'(1);
                    end else begin
                        if (fail_q != CNT_MAX) fail_q <= fail_q + CNT_W'(1);
                        if (!seen_q) begin
                            seen_q <= 1'b1;
                            ffs_q  <= step_idx;
                        end
                    end

                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else if (last_step) begin
                        state <= S_DONE;
                        a_q   <= 1'b0;
                        b_q   <= 1'b0;
                    end else begin
                        step_idx <= next_idx;
                        a_q      <= next_ent.a;
                        b_q      <= next_ent.b;
                        hold_cnt <= next_ent.hold;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign sif.a               = a_q;
    assign sif.b               = b_q;
    assign sif.busy            = (state == S_RUN);
    assign sif.done            = (state == S_DONE);
    assign sif.pass_cnt        = pass_q;
    assign sif.fail_cnt        = fail_q;
    assign sif.fail_seen       = seen_q;
    assign sif.first_fail_step = ffs_q;
endmodule

// File: tb/tb_sva_check_sequencer.sv
// Directed bench for sva_check_sequencer: expected run results are queued at start, a monitor scores each done.
module tb_sva_check_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sva_check_sequencer_if #(.DEPTH(8), .HOLD_W(4), .CNT_W(8)) sif   ();
    sva_check_sequencer_if #(.DEPTH(8), .HOLD_W(4), .CNT_W(4)) sif_s ();

    // The modelled checker: passes only when both stimulus bits are high.
    assign sif.chk_ok   = sif.a & sif.b;
    assign sif_s.chk_ok = sif_s.a & sif_s.b;

    sva_check_sequencer #(.DEPTH(8), .HOLD_W(4), .CNT_W(8)) dut   (.clk(clk), .rst(rst), .sif(sif));
    sva_check_sequencer #(.DEPTH(8), .HOLD_W(4), .CNT_W(4)) dut_s (.clk(clk), .rst(rst), .sif(sif_s));

    typedef struct {
        int cycles;
        int pass;
        int fail;
        int seen;
        int ffs;
    } exp_t;

    exp_t q[$];
    exp_t q_s[$];
    exp_t e_m;
    exp_t e_s;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   cyc_s  = 0;

    function automatic void check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    function automatic exp_t mk(int cycles, int pass, int fail, int seen, int ffs);
        exp_t e;
        e.cycles = cycles;
        e.pass   = pass;
        e.fail   = fail;
        e.seen   = seen;
        e.ffs    = ffs;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
        end else begin
            if (sif.busy) cyc++;
            if (sif.done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done seen with no run expected");
                end else begin
                    e_m = q.pop_front();
                    check("run_cycles", cyc, e_m.cycles);
                    check("pass_cnt", int'(sif.pass_cnt), e_m.pass);
                    check("fail_cnt", int'(sif.fail_cnt), e_m.fail);
                    check("fail_seen", int'(sif.fail_seen), e_m.seen);
                    check("first_fail_step", int'(sif.first_fail_step), e_m.ffs);
                    check("done_ab", int'({sif.a, sif.b}), 0);
                    check("done_busy", int'(sif.busy), 0);
                end
                cyc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            cyc_s = 0;
        end else begin
            if (sif_s.busy) cyc_s++;
            if (sif_s.done) begin
                if (q_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done_s: done seen with no run expected");
                end else begin
                    e_s = q_s.pop_front();
                    check("s_run_cycles", cyc_s, e_s.cycles);
                    check("s_pass_cnt", int'(sif_s.pass_cnt), e_s.pass);
                    check("s_fail_cnt", int'(sif_s.fail_cnt), e_s.fail);
                    check("s_fail_seen", int'(sif_s.fail_seen), e_s.seen);
                    check("s_first_fail_step", int'(sif_s.first_fail_step), e_s.ffs);
                end
                cyc_s = 0;
            end
        end
    end

    task automatic load(input int addr, input bit a, input bit b, input int hold);
        sif.ld_en   = 1'b1;
        sif.ld_addr = 3'(addr);
        sif.ld_a    = a;
        sif.ld_b    = b;
        sif.ld_hold = 4'(hold);
        @(posedge clk); #1;
        sif.ld_en   = 1'b0;
    endtask

    task automatic load_s(input int addr, input bit a, input bit b, input int hold);
        sif_s.ld_en   = 1'b1;
        sif_s.ld_addr = 3'(addr);
        sif_s.ld_a    = a;
        sif_s.ld_b    = b;
        sif_s.ld_hold = 4'(hold);
        @(posedge clk); #1;
        sif_s.ld_en   = 1'b0;
    endtask

    task automatic start_run(input int n);
        sif.num_steps = 4'(n);
        sif.start     = 1'b1;
        @(posedge clk); #1;
        sif.start     = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q.size() != 0 || q_s.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0 || q_s.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d runs still pending after %0d cycles", q.size() + q_s.size(), budget);
            q.delete();
            q_s.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_a"}, int'(sif.a), 0);
        check({tag, "_b"}, int'(sif.b), 0);
        check({tag, "_busy"}, int'(sif.busy), 0);
        check({tag, "_done"}, int'(sif.done), 0);
        check({tag, "_pass"}, int'(sif.pass_cnt), 0);
        check({tag, "_fail"}, int'(sif.fail_cnt), 0);
        check({tag, "_seen"}, int'(sif.fail_seen), 0);
        check({tag, "_ffs"}, int'(sif.first_fail_step), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sif.ld_en = 1'b0;   sif.ld_addr = '0;   sif.ld_a = 1'b0;   sif.ld_b = 1'b0;
        sif.ld_hold = '0;   sif.num_steps = '0; sif.start = 1'b0;
        sif_s.ld_en = 1'b0; sif_s.ld_addr = '0; sif_s.ld_a = 1'b0; sif_s.ld_b = 1'b0;
        sif_s.ld_hold = '0; sif_s.num_steps = '0; sif_s.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Mixed pattern: 10 RUN cycles, 6 pass, 4 fail, first failure at step 0.
        load(0, 0, 0, 0);
        load(1, 1, 1, 0);
        load(2, 1, 0, 0);
        load(3, 0, 1, 0);
        load(4, 0, 0, 0);
        load(5, 1, 1, 4);
        q.push_back(mk(10, 6, 4, 1, 0));
        start_run(6);
        drain(100);
        repeat (3) @(posedge clk);
        #1;
        check("hold_pass", int'(sif.pass_cnt), 6);
        check("hold_fail", int'(sif.fail_cnt), 4);
        check("hold_ab", int'({sif.a, sif.b}), 0);

        // Single long step.
        load(0, 1, 1, 15);
        q.push_back(mk(16, 16, 0, 0, 0));
        start_run(1);
        drain(100);

        // Zero steps: done on the very next cycle, counters cleared.
        q.push_back(mk(0, 0, 0, 0, 0));
        sif.num_steps = '0;
        sif.start     = 1'b1;
        @(posedge clk); #1;
        sif.start     = 1'b0;
        check("zero_done", int'(sif.done), 1);
        check("zero_busy", int'(sif.busy), 0);
        drain(20);

        // Saturation on the narrow-counter instance; num_steps 12 clamps to 8.
        for (int i = 0; i < 8; i++) load_s(i, 1, 0, 15);
        q_s.push_back(mk(128, 0, 15, 1, 0));
        sif_s.num_steps = 4'd12;
        sif_s.start     = 1'b1;
        @(posedge clk); #1;
        sif_s.start     = 1'b0;
        drain(400);

        // Loads and start during RUN are ignored: same result twice.
        load(0, 1, 1, 0);
        load(1, 0, 0, 1);
        q.push_back(mk(3, 1, 2, 1, 1));
        start_run(2);
        sif.ld_en = 1'b1; sif.ld_addr = 3'd1; sif.ld_a = 1'b1; sif.ld_b = 1'b1; sif.ld_hold = 4'd5;
        sif.num_steps = 4'd1; sif.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sif.ld_en = 1'b0; sif.start = 1'b0;
        drain(50);
        q.push_back(mk(3, 1, 2, 1, 1));
        start_run(2);
        drain(50);

        // Reset on the third RUN cycle aborts with no done pulse.
        load(0, 1, 1, 3);
        start_run(1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("abort");
        repeat (8) @(posedge clk);
        #1;

        // Table was cleared by reset: entry 0 is (0,0,0).
        q.push_back(mk(1, 0, 1, 1, 0));
        start_run(1);
        drain(50);

        // Entry 2 written on the start cycle is seen by the run.
        load(0, 1, 1, 0);
        load(1, 1, 1, 0);
        load(2, 0, 0, 0);
        q.push_back(mk(4, 4, 0, 0, 0));
        sif.ld_en = 1'b1; sif.ld_addr = 3'd2; sif.ld_a = 1'b1; sif.ld_b = 1'b1; sif.ld_hold = 4'd1;
        sif.num_steps = 4'd3; sif.start = 1'b1;
        @(posedge clk); #1;
        sif.ld_en = 1'b0; sif.start = 1'b0;
        drain(50);

        // Entry 0 written on the start cycle drives the first step.
        q.push_back(mk(3, 3, 0, 0, 0));
        sif.ld_en = 1'b1; sif.ld_addr = 3'd0; sif.ld_a = 1'b1; sif.ld_b = 1'b1; sif.ld_hold = 4'd2;
        sif.num_steps = 4'd1; sif.start = 1'b1;
        @(posedge clk); #1;
        sif.ld_en = 1'b0; sif.start = 1'b0;
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sva_check_sequencer.md
Name: sva_check_sequencer

Overview:
Programmable stimulus sequencer for the a/b assertion checker. It replays a loaded table of (a, b, hold) steps onto the checked signals. Each cycle it samples the checker's pass/fail result and accumulates pass/fail counts plus the first failing step. It replaces hand-written delay sequences in benches and enables self-checking regressions.

Parameters:
DEPTH, 8, number of table entries (power of 2, >=2)
HOLD_W, 4, width of per-step hold field; a step lasts hold+1 cycles
CNT_W, 8, width of pass/fail counters

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
ld_en  in  1  write one table entry this cycle
ld_addr  in  $clog2(DEPTH)  entry index
ld_a  in  1  value for a at that step
ld_b  in  1  value for b at that step
ld_hold  in  HOLD_W  extra cycles to hold the step
num_steps  in  $clog2(DEPTH)+1  steps to run (0..DEPTH), latched at start
start  in  1  begin a run (single-cycle or level; only accepted in IDLE)
chk_ok  in  1  checker result for the currently driven a/b (combinational, same cycle)
a  out  1  driven stimulus a (registered)
b  out  1  driven stimulus b (registered)
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at end of run
pass_cnt  out  CNT_W  RUN cycles with chk_ok=1
fail_cnt  out  CNT_W  RUN cycles with chk_ok=0
fail_seen  out  1  at least one failure this run
first_fail_step  out  $clog2(DEPTH)  index of step with first failure; valid when fail_seen=1

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State -> IDLE.
  - a, b, busy, done, pass_cnt, fail_cnt, fail_seen, first_fail_step all -> 0.
  - All table entries -> (0, 0, 0).
  - Reset mid-run aborts the run immediately. No done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - a = b = 0.
  - ld_en writes table[ld_addr].
  - When start=1:
    - Clear the counters, fail_seen and first_fail_step.
    - Latch num_steps. A value > DEPTH is clamped to DEPTH.
    - If the latched value is 0: go to DONE with counts 0.
    - Otherwise: go to RUN, load step_idx=0, set a/b = table[0].a/b and hold_cnt = table[0].hold (all on the same edge).
    - ld_en and start in the same cycle: the write completes first, so the run sees the new entry.
- RUN (busy=1):
  - Every posedge samples chk_ok. 1: pass_cnt++. 0: fail_cnt++.
  - On the first 0 of the run, set fail_seen and first_fail_step = step_idx.
  - Counters saturate at 2^CNT_W-1; no wrap.
  - If hold_cnt != 0: decrement it.
  - Else if step_idx == num_steps-1: go to DONE and set a = b = 0.
  - Else: step_idx++, load the next a/b/hold.
  - ld_en and start are ignored in RUN.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start is ignored in DONE.
- Timing:
  - Total RUN cycles = sum over steps of (hold+1).
  - pass_cnt + fail_cnt equals that total unless saturated.
  - done rises the cycle after the last RUN cycle.
  - Results hold their values until the next accepted start or reset.
- Step boundaries: a/b change only at step boundaries. There is no idle gap between consecutive steps.

Test Plan:
- Load (0,0,0),(1,1,0),(1,0,0),(0,1,0),(0,0,0),(1,1,4), num_steps=6, start; bench drives chk_ok=a&&b. Required: 10 RUN cycles, pass_cnt=6, fail_cnt=4, fail_seen=1, first_fail_step=0, then done pulse, a=b=0.
- Single step (1,1,hold=15), num_steps=1, chk_ok=a&&b. Required: busy for 16 cycles, pass_cnt=16, fail_cnt=0, fail_seen=0.
- num_steps=0 with start. Required: done pulses the cycle after start, busy never high, counts 0.
- CNT_W=4, DEPTH=8, all 8 steps with hold=15, chk_ok=0. Required: fail_cnt saturates at 15 and does not wrap; first_fail_step=0.
- Mid-run checks:
  - Assert start and ld_en during RUN: no effect on the run or the table.
  - Assert rst at the 3rd RUN cycle: next cycle all outputs are 0, state IDLE, no done pulse.
  - A new start after reset runs on the cleared table: 1 step of (0,0,0) gives fail_cnt=1.
- Write entry 2 with ld_en in the same cycle as start (num_steps=3). Required: step 2 drives the newly written values.
